// File: rtl/sobel_pkg.sv
// sobel_pkg: shared types and constants for the Sobel window front end.
//   DEF_IMG_W / DEF_IMG_H / DEF_PIX_W : default frame geometry and pixel width
//   pix_t                             : default-width pixel type
//   state_e                           : window generator fill/run state
//   P_TL..P_BR                        : neighbour slot indices, kernel In0..In7 order
package sobel_pkg;

    localparam int unsigned DEF_IMG_W = 512;
    localparam int unsigned DEF_IMG_H = 512;
    localparam int unsigned DEF_PIX_W = 8;

    typedef logic [DEF_PIX_W-1:0] pix_t;

    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Neighbour slots around centre (r,c)
    localparam int unsigned P_TL = 0;  // (r-1,c-1)
    localparam int unsigned P_T  = 1;  // (r-1,c)
    localparam int unsigned P_TR = 2;  // (r-1,c+1)
    localparam int unsigned P_L  = 3;  // (r,c-1)
    localparam int unsigned P_R  = 4;  // (r,c+1)
    localparam int unsigned P_BL = 5;  // (r+1,c-1)
    localparam int unsigned P_B  = 6;  // (r+1,c)
    localparam int unsigned P_BR = 7;  // (r+1,c+1)

    localparam int unsigned NUM_NBR = 8;

endpackage

// File: rtl/sobel_line_buf.sv
// sobel_line_buf: one image line of storage, read-before-write.
//   clk     : clock, rising edge
//   i_en    : write enable
//   i_addr  : column address (shared by read and write)
//   i_wdata : data written at i_addr when i_en
//   o_rdata : combinational read of the old contents at i_addr
// Contents are never cleared; they are refilled by the stream itself.
module sobel_line_buf
    import sobel_pkg::*;
#(
    parameter int unsigned DEPTH  = DEF_IMG_W,
    parameter int unsigned WIDTH  = DEF_PIX_W,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_en,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [WIDTH-1:0]  i_wdata,
    output logic [WIDTH-1:0]  o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Async read returns the value stored before this cycle's write
    assign o_rdata = r_mem[i_addr];

    always_ff @(posedge clk) begin
        if (i_en) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

endmodule

// File: rtl/sobel_window_gen.sv
// sobel_window_gen: raster stream to 3x3 neighbourhood for the Sobel kernel.
//   clk, rst          : clock, synchronous active-high reset
//   in_valid, in_sof  : pixel strobe; in_sof marks pixel (0,0)
//   in_pixel          : grey-scale pixel, row-major order
//   out_valid         : one-cycle strobe, window for an interior centre
//   out_p0..out_p7    : neighbours in kernel In0..In7 order (held between strobes)
//   frame_done        : one-cycle pulse with the final window of a frame
//   out_row, out_col  : centre coordinate, only when SOBEL_WIN_COORD_EN is defined
module sobel_window_gen
    import sobel_pkg::*;
#(
    parameter int unsigned IMG_W = DEF_IMG_W,
    parameter int unsigned IMG_H = DEF_IMG_H,
    parameter int unsigned PIX_W = DEF_PIX_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic                     in_sof,
    input  logic [PIX_W-1:0]         in_pixel,
    output logic                     out_valid,
    output logic [PIX_W-1:0]         out_p0,
    output logic [PIX_W-1:0]         out_p1,
    output logic [PIX_W-1:0]         out_p2,
    output logic [PIX_W-1:0]         out_p3,
    output logic [PIX_W-1:0]         out_p4,
    output logic [PIX_W-1:0]         out_p5,
    output logic [PIX_W-1:0]         out_p6,
    output logic [PIX_W-1:0]         out_p7,
    output logic                     frame_done
`ifdef SOBEL_WIN_COORD_EN
    ,
    output logic [$clog2(IMG_H)-1:0] out_row,
    output logic [$clog2(IMG_W)-1:0] out_col
`endif
);

    localparam int unsigned COL_W = $clog2(IMG_W);
    localparam int unsigned ROW_W = $clog2(IMG_H);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
    localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;
    state_e           r_state;
    logic             r_out_valid;
    logic             r_frame_done;
    logic [PIX_W-1:0] r_p [NUM_NBR];

    // Two most recent window columns, index 0 = top row
    logic [PIX_W-1:0] r_win_l [3];
    logic [PIX_W-1:0] r_win_c [3];

    logic             w_sof;
    logic [COL_W-1:0] w_col_eff;
    logic [ROW_W-1:0] w_row_eff;
    logic             w_col_last;
    logic             w_row_last;
    logic [COL_W-1:0] w_col_nxt;
    logic [ROW_W-1:0] w_row_nxt;
    state_e           w_state_nxt;
    logic             w_emit;
    logic             w_last_px;
    logic             w_lb_en;
    logic [PIX_W-1:0] w_top_rd;
    logic [PIX_W-1:0] w_mid_rd;

    // A start-of-frame pixel is (0,0) whatever the counters say
    assign w_sof      = in_valid & in_sof;
    assign w_col_eff  = w_sof ? '0 : r_col;
    assign w_row_eff  = w_sof ? '0 : r_row;
    assign w_col_last = (w_col_eff == COL_LAST);
    assign w_row_last = (w_row_eff == ROW_LAST);
    assign w_lb_en    = in_valid & ~rst;

    // Window is complete once columns c-2..c are present; centre is (r-1,c-1)
    assign w_emit    = in_valid & ~w_sof & (r_state == ST_RUN) & (w_col_eff >= COL_TWO);
    assign w_last_px = in_valid & ~w_sof & (r_state == ST_RUN) & w_row_last & w_col_last;

    always_comb begin
        w_col_nxt   = w_col_eff + COL_W'(1);
        w_row_nxt   = w_row_eff;
        w_state_nxt = r_state;
        if (w_col_last) begin
            w_col_nxt = '0;
            w_row_nxt = w_row_last ? '0 : w_row_eff + ROW_W'(1);
        end
        if (w_sof) begin
            w_state_nxt = ST_FILL;
        end else if (r_state == ST_FILL && w_row_eff == ROW_TWO && w_col_eff == '0) begin
            w_state_nxt = ST_RUN;
        end else if (w_last_px) begin
            w_state_nxt = ST_FILL;
        end
    end

    // lb_top holds row r-2, lb_mid holds row r-1; top takes mid's old value
    sobel_line_buf #(
        .DEPTH  (IMG_W),
        .WIDTH  (PIX_W),
        .ADDR_W (COL_W)
    ) u_lb_top (
        .clk     (clk),
        .i_en    (w_lb_en),
        .i_addr  (w_col_eff),
        .i_wdata (w_mid_rd),
        .o_rdata (w_top_rd)
    );

    sobel_line_buf #(
        .DEPTH  (IMG_W),
        .WIDTH  (PIX_W),
        .ADDR_W (COL_W)
    ) u_lb_mid (
        .clk     (clk),
        .i_en    (w_lb_en),
        .i_addr  (w_col_eff),
        .i_wdata (in_pixel),
        .o_rdata (w_mid_rd)
    );

    // Window shift; no reset needed because column 0 flushes the stale columns
    always_ff @(posedge clk) begin
        if (in_valid) begin
            for (int i = 0; i < 3; i++) begin
                r_win_l[i] <= (w_col_eff == '0) ? '0 : r_win_c[i];
            end
            r_win_c[0] <= w_top_rd;
            r_win_c[1] <= w_mid_rd;
            r_win_c[2] <= in_pixel;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col        <= '0;
            r_row        <= '0;
            r_state      <= ST_FILL;
            r_out_valid  <= 1'b0;
            r_frame_done <= 1'b0;
            for (int i = 0; i < NUM_NBR; i++) begin
                r_p[i] <= '0;
            end
        end else begin
            r_out_valid  <= w_emit;
            r_frame_done <= w_last_px;
            if (in_valid) begin
                r_col   <= w_col_nxt;
                r_row   <= w_row_nxt;
                r_state <= w_state_nxt;
            end
            if (w_emit) begin
                r_p[P_TL] <= r_win_l[0];
                r_p[P_T]  <= r_win_c[0];
                r_p[P_TR] <= w_top_rd;
                r_p[P_L]  <= r_win_l[1];
                r_p[P_R]  <= w_mid_rd;
                r_p[P_BL] <= r_win_l[2];
                r_p[P_B]  <= r_win_c[2];
                r_p[P_BR] <= in_pixel;
            end
        end
    end

`ifdef SOBEL_WIN_COORD_EN
    logic [ROW_W-1:0] r_out_row;
    logic [COL_W-1:0] r_out_col;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_row <= '0;
            r_out_col <= '0;
        end else if (w_emit) begin
            r_out_row <= w_row_eff - ROW_W'(1);
            r_out_col <= w_col_eff - COL_W'(1);
        end
    end

    assign out_row = r_out_row;
    assign out_col = r_out_col;
`endif

    assign out_valid  = r_out_valid;
    assign frame_done = r_frame_done;
    assign out_p0     = r_p[P_TL];
    assign out_p1     = r_p[P_T];
    assign out_p2     = r_p[P_TR];
    assign out_p3     = r_p[P_L];
    assign out_p4     = r_p[P_R];
    assign out_p5     = r_p[P_BL];
    assign out_p6     = r_p[P_B];
    assign out_p7     = r_p[P_BR];

endmodule

// File: tb/tb_sobel_window_gen.sv
// tb_sobel_window_gen: directed bench for sobel_window_gen on a 4x4 image.
//   Pixel (r,c) = 16*r+c, or 0xFF-(16*r+c) for the inverted frame.
//   Coordinate ports are checked when SOBEL_WIN_COORD_EN is defined.
module tb_sobel_window_gen;

    localparam int W = 4;
    localparam int H = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_sof = 1'b0;
    logic [7:0] in_pixel = 8'h00;
    logic       out_valid;
    logic [7:0] out_p0, out_p1, out_p2, out_p3, out_p4, out_p5, out_p6, out_p7;
    logic       frame_done;
`ifdef SOBEL_WIN_COORD_EN
    logic [1:0] out_row;
    logic [1:0] out_col;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int n_win    = 0;
    int n_done   = 0;
    logic [7:0] exp_p [8];

    sobel_window_gen #(
        .IMG_W (W),
        .IMG_H (H),
        .PIX_W (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_sof     (in_sof),
        .in_pixel   (in_pixel),
        .out_valid  (out_valid),
        .out_p0     (out_p0),
        .out_p1     (out_p1),
        .out_p2     (out_p2),
        .out_p3     (out_p3),
        .out_p4     (out_p4),
        .out_p5     (out_p5),
        .out_p6     (out_p6),
        .out_p7     (out_p7),
        .frame_done (frame_done)
`ifdef SOBEL_WIN_COORD_EN
        ,
        .out_row    (out_row),
        .out_col    (out_col)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pix(input int r, input int c, input bit inv);
        logic [7:0] v;
        v = 8'(16 * r + c);
        return inv ? (8'hFF - v) : v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass = n_pass + 1;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_p();
        chk("p0", {24'd0, out_p0}, {24'd0, exp_p[0]});
        chk("p1", {24'd0, out_p1}, {24'd0, exp_p[1]});
        chk("p2", {24'd0, out_p2}, {24'd0, exp_p[2]});
        chk("p3", {24'd0, out_p3}, {24'd0, exp_p[3]});
        chk("p4", {24'd0, out_p4}, {24'd0, exp_p[4]});
        chk("p5", {24'd0, out_p5}, {24'd0, exp_p[5]});
        chk("p6", {24'd0, out_p6}, {24'd0, exp_p[6]});
        chk("p7", {24'd0, out_p7}, {24'd0, exp_p[7]});
    endtask

    // Push pixel (r,c); check the registered outputs #1 after the accepting edge,
    // then run idle cycles in which nothing may be emitted and out_p* must hold.
    task automatic px(input int r, input int c, input bit inv, input bit sof,
                      input bit emit, input bit done, input int idle);
        in_valid = 1'b1;
        in_sof   = sof;
        in_pixel = pix(r, c, inv);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        if (out_valid === 1'b1) n_win++;
        if (frame_done === 1'b1) n_done++;
        chk("out_valid", {31'd0, out_valid}, {31'd0, emit});
        chk("frame_done", {31'd0, frame_done}, {31'd0, done});
        if (emit) begin
            exp_p[0] = pix(r - 2, c - 2, inv);
            exp_p[1] = pix(r - 2, c - 1, inv);
            exp_p[2] = pix(r - 2, c, inv);
            exp_p[3] = pix(r - 1, c - 2, inv);
            exp_p[4] = pix(r - 1, c, inv);
            exp_p[5] = pix(r, c - 2, inv);
            exp_p[6] = pix(r, c - 1, inv);
            exp_p[7] = pix(r, c, inv);
`ifdef SOBEL_WIN_COORD_EN
            chk("out_row", {30'd0, out_row}, 32'(r - 1));
            chk("out_col", {30'd0, out_col}, 32'(c - 1));
`endif
        end
        chk_p();
        for (int i = 0; i < idle; i++) begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) n_win++;
            chk("gap_valid", {31'd0, out_valid}, 32'd0);
            chk("gap_done", {31'd0, frame_done}, 32'd0);
            chk_p();
        end
    endtask

    task automatic frame(input bit inv, input int idle);
        int w0;
        w0 = n_win;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                px(r, c, inv, (r == 0 && c == 0), (r >= 2 && c >= 2),
                   (r == H - 1 && c == W - 1), idle);
            end
        end
        chk("frame_windows", 32'(n_win - w0), 32'((W - 2) * (H - 2)));
    endtask

    initial begin
        int w0;
        int d0;
        for (int i = 0; i < 8; i++) exp_p[i] = 8'h00;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_done", {31'd0, frame_done}, 32'd0);
        chk_p();
        rst = 1'b0;

        // Continuous frame; first window after (2,2) = 00,01,02,10,12,20,21,22
        d0 = n_done;
        frame(1'b0, 0);
        chk("done_count_1", 32'(n_done - d0), 32'd1);

        // Same frame with 1-0-0 valid pattern
        frame(1'b0, 2);

        // Back-to-back frames, second inverted
        w0 = n_win;
        d0 = n_done;
        frame(1'b0, 0);
        frame(1'b1, 0);
        chk("b2b_windows", 32'(n_win - w0), 32'd8);
        chk("b2b_done", 32'(n_done - d0), 32'd2);

        // Reset at pixel (2,1) with in_valid high: reset wins
        w0 = n_win;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < W; c++) begin
                if (r == 2 && c == 1) break;
                px(r, c, 1'b0, (r == 0 && c == 0), 1'b0, 1'b0, 0);
            end
        end
        rst      = 1'b1;
        in_valid = 1'b1;
        in_pixel = pix(2, 1, 1'b0);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) exp_p[i] = 8'h00;
        chk("midrst_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_done", {31'd0, frame_done}, 32'd0);
        chk_p();
        // Rest of the aborted frame lands in rows 0-1 of the counters: no output
        for (int r = 2; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (r == 2 && c < 2) continue;
                px(r, c, 1'b0, 1'b0, 1'b0, 1'b0, 0);
            end
        end
        chk("rst_abort_windows", 32'(n_win - w0), 32'd0);
        frame(1'b0, 0);

        // in_sof at pixel (3,0): aborted frame gets no frame_done
        d0 = n_done;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < W; c++) begin
                px(r, c, 1'b0, (r == 0 && c == 0), (r >= 2 && c >= 2), 1'b0, 0);
            end
        end
        frame(1'b1, 0);
        chk("sof_done_count", 32'(n_done - d0), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sobel_window_gen.md
# sobel_window_gen

Raster-to-window stage that sits directly upstream of the Sobel `kernel`. It accepts a grey-scale pixel stream, one pixel per cycle in row-major order, and buffers two lines. For every interior pixel it presents the 8-neighbourhood on ports that wire one-to-one onto kernel `In0`..`In7`. It replaces the bench-side address arithmetic with synthesisable line buffering.

## Interface
- `IMG_W`, default 512: pixels per row, ≥ 3.
- `IMG_H`, default 512: rows per frame, ≥ 3.
- `PIX_W`, default 8: pixel width.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `in_valid` in 1: `in_pixel` is valid this cycle.
- `in_sof` in 1: qualified by `in_valid`; the pixel is (row 0, col 0).
- `in_pixel` in PIX_W: input pixel.
- `out_valid` in-direction out, 1: window valid, one-cycle strobe.
- `out_p0`..`out_p7` out, PIX_W each, neighbours of the centre (r,c):
  - p0 = (r-1,c-1), p1 = (r-1,c), p2 = (r-1,c+1)
  - p3 = (r,c-1), p4 = (r,c+1)
  - p5 = (r+1,c-1), p6 = (r+1,c), p7 = (r+1,c+1)
- `frame_done` out 1: one-cycle pulse after the last pixel of a frame.
- `out_row` out `$clog2(IMG_H)`: centre row. Present only under `SOBEL_WIN_COORD_EN`.
- `out_col` out `$clog2(IMG_W)`: centre column. Present only under `SOBEL_WIN_COORD_EN`.

## Operation
- Column counter `col` and row counter `row` advance only on `in_valid`.
  - `col` wraps at IMG_W-1 and increments `row`.
  - `row` wraps at IMG_H-1 to 0.
- `in_sof` with `in_valid`: the pixel is taken as (0,0) regardless of counter state. The counters resync, state goes to FILL, and a partial frame is abandoned without `frame_done`.
- Line buffers:
  - Two IMG_W-deep arrays: `lb_top` holds row r-2 and `lb_mid` holds row r-1, both indexed by `col`.
  - On each accepted pixel, read `lb_top[col]` and `lb_mid[col]` (read-before-write).
  - Then write `lb_top[col] <= lb_mid[col]` (old value) and `lb_mid[col] <= in_pixel`.
- Window: a 3×3 register array, shifted left one column per accepted pixel. The new right column is {`lb_top`, `lb_mid`, `in_pixel`}. The shift is flushed at column 0, so no cross-row mixing is used.
- States:
  - FILL: reset state; covers rows 0–1. No output.
  - RUN: rows 2..IMG_H-1.
  - FILL → RUN on the first accepted pixel of row 2.
  - RUN → FILL on the accepted pixel (IMG_H-1, IMG_W-1), which also issues `frame_done`.
- Emission: in RUN, accepting pixel (r,c) with c ≥ 2 emits the window centred on (r-1,c-1).
  - Only interior centres are ever emitted: rows 1..IMG_H-2, cols 1..IMG_W-2.
  - Exactly (IMG_W-2)·(IMG_H-2) windows are emitted per frame.
  - Border centres are never emitted; downstream treats them as 0.
- Pixel values pass through unmodified. There is no arithmetic on pixel data.

## Timing
- Latency: `out_valid` and `out_p*` are registered, one cycle after the accepted pixel that completes the window.
- `out_p*` hold their value while `out_valid` is 0.
- `frame_done` asserts one cycle after the last pixel is accepted, coincident with the final `out_valid`.
- No backpressure: the downstream stage must accept every window. `in_valid` gaps of any length are allowed and stall everything.
- Reset values:
  - `out_valid`, `frame_done`, all `out_p*`, `out_row`, `out_col` = 0.
  - Counters = 0; state = FILL.
  - Line buffer contents are not cleared; they are don't-care until refilled.
- `rst` has priority over `in_valid`/`in_sof` in the same cycle. Reset mid-frame drops the frame and emits no further windows until rows 0–1 refill.
- `in_sof` on the cycle after the last pixel of a frame: a normal back-to-back frame.

## Configuration
- `SOBEL_WIN_COORD_EN` defined: `out_row`/`out_col` ports exist. They are registered alongside `out_valid` and give the centre coordinate, (r-1,c-1).
- Undefined: the ports and their registers are absent. Window behaviour and latency are identical.

## Structure
- Shared package `sobel_pkg`:
  - `pix_t` (logic [PIX_W-1:0])
  - default IMG_W/IMG_H constants
  - FILL/RUN state enum
  - neighbour index constants P_TL..P_BR = 0..7
- One sub-module, `sobel_line_buf`: a single IMG_W-deep read-before-write array with an enable. It is instantiated twice.

## Test plan
- IMG_W=IMG_H=4, pixel = 16·r+c, continuous `in_valid`:
  - 4 windows are emitted.
  - The first appears one cycle after pixel (2,2) with p0..p7 = 00,01,02,10,12,20,21,22.
  - The last (centre 2,2) has p7 = 0x33.
  - `frame_done` is coincident with the last window.
- Same image with `in_valid` toggled 1-0-0 (random gaps): identical window sequence; `out_valid` never asserts in a gap cycle.
- Two back-to-back frames, the second with pixel = 0xFF-(16·r+c): 8 windows total; the second frame's first window has p0 = 0xFF with no frame-1 data.
- `rst` pulsed at pixel (2,1), then a fresh frame: no window from the aborted frame; 4 correct windows afterwards; all outputs 0 during reset.
- `in_sof` asserted at pixel (3,0) mid-frame: no `frame_done` for the aborted frame; the resynced frame yields 4 correct windows.
- 512×512 from `lena_gray.txt` through `sobel_window_gen` + `kernel`: 510·510 windows, with output matching the golden `sobel_out.txt` at interior pixels.
